// File: rtl/div_radix2_iter.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU: one quotient bit per clock, {rem, quot} result.
// Optional build macro DIV_EARLY_EXIT_EN: skip iteration when b==0 or |a|<|b|.
module div_radix2_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 valid,
  input  logic                 sign,
  output logic                 div_stall,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_rem, r_quot, r_div, r_a;
  logic               r_neg_q, r_neg_r, r_dz;
  logic [2*WIDTH-1:0] r_result;

  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic               w_start, w_last, w_early, w_fits;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_rem_nxt, w_quot_nxt, w_q_fix, w_r_fix;

  assign w_abs_a = (sign & a[WIDTH-1]) ? -a : a;
  assign w_abs_b = (sign & b[WIDTH-1]) ? -b : b;
  assign w_start = (r_state == S_IDLE) & valid & ~flush;
  assign w_last  = (r_state == S_CALC) & (r_cnt == CW'(WIDTH-1));

`ifdef DIV_EARLY_EXIT_EN
  logic [2*WIDTH-1:0] w_early_res;
  assign w_early     = (b == '0) | (w_abs_a < w_abs_b);
  assign w_early_res = (b == '0) ? {a, {WIDTH{1'b1}}} : {a, {WIDTH{1'b0}}};
`else
  assign w_early = 1'b0;
`endif

  // Partial remainder stays below the divisor, so a WIDTH+1-bit difference carries a valid sign bit.
  assign w_trial    = {r_rem, r_quot[WIDTH-1]} - {1'b0, r_div};
  assign w_fits     = ~w_trial[WIDTH];
  assign w_rem_nxt  = w_fits ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_quot[WIDTH-1]};
  assign w_quot_nxt = {r_quot[WIDTH-2:0], w_fits};

  assign w_q_fix = r_dz ? {WIDTH{1'b1}} : (r_neg_q ? -w_quot_nxt : w_quot_nxt);
  assign w_r_fix = r_dz ? r_a           : (r_neg_r ? -w_rem_nxt  : w_rem_nxt);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    w_next    = r_state;
    div_stall = 1'b0;
    case (r_state)
      S_IDLE:  if (w_start) w_next = w_early ? S_DONE : S_CALC;
      S_CALC:  if (w_last)  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
    div_stall = ~flush & ((r_state == S_CALC) | ((r_state == S_IDLE) & valid));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_div    <= '0;
      r_a      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_result <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (valid) begin
          r_rem   <= '0;
          r_quot  <= w_abs_a;
          r_div   <= w_abs_b;
          r_a     <= a;
          r_dz    <= (b == '0);
          r_neg_q <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
          r_neg_r <= sign & a[WIDTH-1];
          r_cnt   <= '0;
`ifdef DIV_EARLY_EXIT_EN
          if (w_early) r_result <= w_early_res;
`endif
        end
        S_CALC: begin
          r_rem  <= w_rem_nxt;
          r_quot <= w_quot_nxt;
          r_cnt  <= r_cnt + 1'b1;
          // Result lands on the final iteration edge so it is already visible in DONE.
          if (w_last) r_result <= {w_r_fix, w_q_fix};
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule
